// File: rtl/wb_pkg.sv
// Shared Wishbone types and constants for bus masters.
// Used by the CPU bridge and the reusable timeout counter.
package wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = WB_DATA_W / 8;

    localparam logic [WB_SEL_W-1:0] WB_SEL_ALL = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } wb_state_e;

    // Reads select every byte lane; writes use the core's strobes.
    function automatic logic [WB_SEL_W-1:0] wb_sel(
        input logic [WB_SEL_W-1:0] wstrb
    );
        return (wstrb == '0) ? WB_SEL_ALL : wstrb;
    endfunction

endpackage

// File: rtl/wb_bus_timeout.sv
// Saturating bus-cycle watchdog shared by Wishbone masters.
// expired flags the cycle in which the count reaches LIMIT.
module wb_bus_timeout #(
    parameter int unsigned LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);
    localparam logic [W-1:0] LAST = W'((LIMIT == 0) ? 0 : LIMIT - 1);
    localparam logic [W-1:0] MAX  = W'(LIMIT);

    logic [W-1:0] count;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run && count != MAX) begin
            count <= count + W'(1);
        end
    end

    assign expired = (LIMIT != 0) && run && (count >= LAST);

endmodule

// File: rtl/wb_cpu_master.sv
// picorv32 native memory port to single-outstanding pipelined
// Wishbone master with error reporting and bus timeout.
module wb_cpu_master
    import wb_pkg::*;
#(
    parameter int unsigned          TIMEOUT_CYCLES = 255,
    parameter logic [WB_DATA_W-1:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_mem_valid,
    input  logic                 i_mem_instr,
    input  logic [WB_ADDR_W-1:0] i_mem_addr,
    input  logic [WB_DATA_W-1:0] i_mem_wdata,
    input  logic [WB_SEL_W-1:0]  i_mem_wstrb,
    output logic                 o_mem_ready,
    output logic [WB_DATA_W-1:0] o_mem_rdata,
    output logic                 o_wb_cyc,
    output logic                 o_wb_stb,
    output logic                 o_wb_we,
    output logic [WB_ADDR_W-1:0] o_wb_addr,
    output logic [WB_DATA_W-1:0] o_wb_data,
    output logic [WB_SEL_W-1:0]  o_wb_sel,
    input  logic                 i_wb_stall,
    input  logic                 i_wb_ack,
    input  logic [WB_DATA_W-1:0] i_wb_data,
    input  logic                 i_wb_err,
    output logic                 o_bus_err,
    output logic                 o_err_pulse
);

    wb_state_e state;
    logic      is_read;
    logic      cooldown;
    logic      accept;
    logic      in_cycle;
    logic      finish;
    logic      failed;
    logic      run;
    logic      expired;
    logic      instr_unused;

    assign instr_unused = i_mem_instr;

    assign accept   = (state == IDLE) && i_mem_valid && !cooldown;
    assign in_cycle = (state == REQ) || (state == WAIT);
    assign run      = in_cycle && !i_wb_ack && !i_wb_err;
    assign finish   = i_wb_ack || i_wb_err || expired;
    // Without ack, finishing can only mean err or timeout.
    assign failed   = i_wb_err || !i_wb_ack;

    wb_bus_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .clear    (accept),
        .run      (run),
        .expired  (expired)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            is_read     <= 1'b0;
            cooldown    <= 1'b0;
            o_mem_ready <= 1'b0;
            o_mem_rdata <= '0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
            o_wb_sel    <= '0;
            o_bus_err   <= 1'b0;
            o_err_pulse <= 1'b0;
        end else begin
            o_mem_ready <= 1'b0;
            o_err_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    cooldown <= 1'b0;
                    if (accept) begin
                        state     <= REQ;
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= |i_mem_wstrb;
                        o_wb_sel  <= wb_sel(i_mem_wstrb);
                        o_wb_addr <= i_mem_addr;
                        o_wb_data <= i_mem_wdata;
                        is_read   <= ~|i_mem_wstrb;
                    end
                end
                REQ, WAIT: begin
                    if (finish) begin
                        state       <= DONE;
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_mem_ready <= 1'b1;
                        if (failed) begin
                            o_bus_err   <= 1'b1;
                            o_err_pulse <= 1'b1;
                            o_mem_rdata <= is_read ? ERR_RDATA : '0;
                        end else begin
                            o_mem_rdata <= is_read ? i_wb_data : '0;
                        end
                    end else if (state == REQ && !i_wb_stall) begin
                        state    <= WAIT;
                        o_wb_stb <= 1'b0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    cooldown <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
